// File: rtl/shift_serializer.sv
// shift_serializer: parallel-to-serial shift stage with ready/valid on both sides.
// A WIDTH-bit word is accepted on an upstream handshake and shifted out one bit
// per accepted downstream beat, LSB-first or MSB-first as chosen when the word loads.
// A new word may load on the accepted last beat of the current one, so the serial
// output can run without gaps.
// Optional build macro SHIFT_SER_PARITY_EN appends one even-parity beat per word.
module shift_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

`ifdef SHIFT_SER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Shift register holds the data bits plus, when enabled, the parity bit
  // placed so that it leaves last in either direction.
  localparam int SR_W = WIDTH + PAR_W;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SR_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [SR_W-1:0]  shreg;
  logic [CNT_W-1:0] cnt;
  logic             dir;

  logic [SR_W-1:0]  load_word;
  logic [SR_W-1:0]  shifted;
  logic [CNT_W-1:0] cnt_inc;
  logic             load_bit;
  logic             shift_bit;
  logic             load;
  logic             advance;

  // Frame the incoming word: parity sits beyond the last data bit for the chosen direction.
`ifdef SHIFT_SER_PARITY_EN
  assign load_word = in_dir ? {in_data, ^in_data} : {^in_data, in_data};
`else
  assign load_word = in_data;
`endif

  // Zero-filled shift towards the output end of the register.
  assign shifted   = dir ? {shreg[SR_W-2:0], 1'b0} : {1'b0, shreg[SR_W-1:1]};
  assign load_bit  = in_dir ? load_word[SR_W-1] : load_word[0];
  assign shift_bit = dir ? shifted[SR_W-1] : shifted[0];
  assign cnt_inc   = cnt + CNT_W'(1);

  // Ready when idle, or when the final beat is leaving this very cycle.
  // ser_ready reaches in_ready only through this term.
  assign in_ready = ~rst & ((state == IDLE) | ((state == SHIFT) & ser_last & ser_ready));
  assign load     = in_valid & in_ready;
  assign advance  = (state == SHIFT) & ser_ready;

  // Control FSM with registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (load) begin
      // Covers both a load from IDLE and a back-to-back load on the last beat.
      state     <= SHIFT;
      shreg     <= load_word;
      dir       <= in_dir;
      cnt       <= '0;
      ser_out   <= load_bit;
      ser_valid <= 1'b1;
      ser_last  <= 1'b0;
      busy      <= 1'b1;
    end else if (advance) begin
      shreg <= shifted;
      cnt   <= cnt_inc;
      if (ser_last) begin
        state     <= IDLE;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        ser_out  <= shift_bit;
        ser_last <= (cnt_inc == TERM);
      end
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: self-checking bench for shift_serializer (WIDTH = 8).
// Directed scenarios compare the collected serial stream against literal bit
// patterns; the random scenario compares every cycle against a queue model of
// pending serial bits.
module tb_shift_serializer;

  localparam int W = 8;
`ifdef SHIFT_SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles;
  int accepts;
  bit obs_bits[$];
  bit obs_last[$];

  shift_serializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .ser_ready(ser_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record what the DUT shows in the current cycle, then advance one clock.
  task automatic tick();
    #2;
    if (ser_valid === 1'b1) valid_cycles++;
    if (ser_valid === 1'b1 && ser_ready) begin
      obs_bits.push_back(ser_out);
      obs_last.push_back(ser_last);
    end
    if (in_ready === 1'b1 && in_valid) accepts++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_bits.delete();
    obs_last.delete();
    valid_cycles = 0;
    accepts = 0;
  endtask

  function automatic logic [31:0] vec(input bit q[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  // Run the clock until n beats have been collected or the budget runs out.
  task automatic wait_beats(input int n, input string name);
    int g = 0;
    while (obs_bits.size() < n && g < 80) begin
      tick();
      g++;
    end
    n_checks++;
    if (obs_bits.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats, want %0d", name, obs_bits.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_dir = 1'b0; ser_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_c1: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks += 3;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_c2: got %b want 0", in_ready); end
    if (ser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks += 4;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b want 0", busy); end
    if (ser_out !== 1'b0) begin n_fail++; $display("FAIL release_ser_out: got %b want 0", ser_out); end
    if (ser_last !== 1'b0) begin n_fail++; $display("FAIL release_ser_last: got %b want 0", ser_last); end
    clear_obs();
    tick();
    n_checks++;
    if (ser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_load: ser_valid got %b want 0", ser_valid); end
    $display("test_reset done");
  endtask

  task automatic test_lsb();
    clear_obs();
    in_valid = 1'b1; in_data = 8'hA5; in_dir = 1'b0; ser_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lsb_accept_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b1;
    wait_beats(8, "lsb");
    #1;
    n_checks += 5;
    if (vec(obs_bits) !== 32'h0000_00A5) begin n_fail++; $display("FAIL lsb_bits: got %h want 000000a5", vec(obs_bits)); end
    if (vec(obs_last) !== 32'h0000_0080) begin n_fail++; $display("FAIL lsb_last: got %h want 00000080", vec(obs_last)); end
    if (valid_cycles != 8) begin n_fail++; $display("FAIL lsb_valid_cycles: got %0d want 8", valid_cycles); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lsb_ready_after: got %b want 1", in_ready); end
    if (ser_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_valid_after: got %b want 0", ser_valid); end
    $display("test_lsb bits=%h last=%h", vec(obs_bits), vec(obs_last));
  endtask

  task automatic test_msb_stall();
    int stalled [8];
    int g = 0;
    clear_obs();
    for (int i = 0; i < 8; i++) stalled[i] = 0;
    in_valid = 1'b1; in_data = 8'h81; in_dir = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h7E; in_dir = 1'b0;
    while (obs_bits.size() < 8 && g < 80) begin
      int idx = obs_bits.size();
      if ((idx == 1 || idx == 4) && stalled[idx] < 3) begin
        ser_ready = 1'b0;
        stalled[idx]++;
        #1;
        n_checks += 2;
        if (ser_valid !== 1'b1) begin n_fail++; $display("FAIL msb_stall_valid: beat %0d got %b want 1", idx, ser_valid); end
        if (ser_out !== 1'b0) begin n_fail++; $display("FAIL msb_stall_hold: beat %0d got %b want 0", idx, ser_out); end
      end else begin
        ser_ready = 1'b1;
      end
      tick();
      g++;
    end
    ser_ready = 1'b1;
    n_checks += 3;
    if (vec(obs_bits) !== 32'h0000_0081) begin n_fail++; $display("FAIL msb_bits: got %h want 00000081", vec(obs_bits)); end
    if (vec(obs_last) !== 32'h0000_0080) begin n_fail++; $display("FAIL msb_last: got %h want 00000080", vec(obs_last)); end
    if (valid_cycles != 14) begin n_fail++; $display("FAIL msb_valid_cycles: got %0d want 14", valid_cycles); end
    $display("test_msb_stall bits=%h valid_cycles=%0d", vec(obs_bits), valid_cycles);
  endtask

  task automatic test_back_to_back();
    int g = 0;
    clear_obs();
    in_valid = 1'b1; in_data = 8'h0F; in_dir = 1'b0; ser_ready = 1'b1;
    tick();
    in_data = 8'hF0;
    while (obs_bits.size() < 16 && g < 80) begin
      if (accepts >= 2) in_valid = 1'b0;
      if (obs_bits.size() > 0) begin
        #1;
        n_checks++;
        if (ser_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble: after beat %0d got %b want 1", obs_bits.size(), ser_valid); end
      end
      tick();
      g++;
    end
    in_valid = 1'b0;
    n_checks += 3;
    if (vec(obs_bits) !== 32'h0000_F00F) begin n_fail++; $display("FAIL b2b_bits: got %h want 0000f00f", vec(obs_bits)); end
    if (vec(obs_last) !== 32'h0000_8080) begin n_fail++; $display("FAIL b2b_last: got %h want 00008080", vec(obs_last)); end
    if (accepts != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
    $display("test_back_to_back bits=%h last=%h", vec(obs_bits), vec(obs_last));
  endtask

  task automatic test_reset_mid();
    clear_obs();
    in_valid = 1'b1; in_data = 8'hC3; in_dir = 1'b0; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_beats(3, "mid_pre");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks += 3;
    if (ser_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", ser_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    clear_obs();
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    in_valid = 1'b0;
    wait_beats(8, "mid_post");
    n_checks += 3;
    if (vec(obs_bits) !== 32'h0000_0001) begin n_fail++; $display("FAIL mid_bits: got %h want 00000001", vec(obs_bits)); end
    if (vec(obs_last) !== 32'h0000_0080) begin n_fail++; $display("FAIL mid_last: got %h want 00000080", vec(obs_last)); end
    if (valid_cycles != 8) begin n_fail++; $display("FAIL mid_valid_cycles: got %0d want 8", valid_cycles); end
    $display("test_reset_mid bits=%h", vec(obs_bits));
  endtask

`ifdef SHIFT_SER_PARITY_EN
  task automatic test_parity();
    clear_obs();
    in_valid = 1'b1; in_data = 8'h07; in_dir = 1'b0; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_beats(9, "parity");
    n_checks += 3;
    if (vec(obs_bits) !== 32'h0000_0107) begin n_fail++; $display("FAIL parity_bits: got %h want 00000107", vec(obs_bits)); end
    if (vec(obs_last) !== 32'h0000_0100) begin n_fail++; $display("FAIL parity_last: got %h want 00000100", vec(obs_last)); end
    if (valid_cycles != 9) begin n_fail++; $display("FAIL parity_valid_cycles: got %0d want 9", valid_cycles); end
    $display("test_parity bits=%h last=%h", vec(obs_bits), vec(obs_last));
  endtask
`endif

  // Model: a queue of serial bits still owed downstream. Each accepted word
  // appends its bits in transmit order; each accepted beat removes the head.
  task automatic test_random();
    bit mq[$];
    int words = 0;
    for (int c = 0; c < 700; c++) begin
      bit exp_v, exp_rdy, do_pop, do_push;
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = W'($urandom);
      in_dir    = 1'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_v   = (mq.size() > 0);
      exp_rdy = !rst && (mq.size() == 0 || (mq.size() == 1 && ser_ready));
      n_checks += 3;
      if (ser_valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, ser_valid, exp_v); end
      if (busy !== exp_v) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, exp_v); end
      if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
      if (exp_v) begin
        n_checks += 2;
        if (ser_out !== mq[0]) begin n_fail++; $display("FAIL rnd_ser_out c%0d: got %b want %b", c, ser_out, mq[0]); end
        if (ser_last !== (mq.size() == 1)) begin n_fail++; $display("FAIL rnd_ser_last c%0d: got %b want %b", c, ser_last, mq.size() == 1); end
      end
      do_pop  = exp_v && ser_ready && !rst;
      do_push = exp_rdy && in_valid;
      tick();
      if (rst) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          words++;
          for (int i = 0; i < W; i++) mq.push_back(in_dir ? in_data[W-1-i] : in_data[i]);
          if (NB > W) mq.push_back(^in_data);
        end
      end
    end
    rst = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
    $display("test_random words=%0d", words);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; ser_ready = 1'b0;
    clear_obs();
    test_reset();
`ifdef SHIFT_SER_PARITY_EN
    test_parity();
`else
    test_lsb();
    test_msb_stall();
    test_back_to_back();
    test_reset_mid();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-to-serial shift stage sitting directly downstream of the 8-bit operand select/register stage.
- Accepts one WIDTH-bit word per valid/ready handshake.
- Shifts the word out one bit per accepted beat, LSB-first or MSB-first, under a downstream ready/valid handshake.
- Provides full throughput: a new word can load on the last beat of the previous one.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  parallel word from upstream stage
- in_dir  input  1  0 = LSB-first, 1 = MSB-first; sampled with in_data
- in_valid  input  1  upstream word valid
- in_ready  output  1  stage can accept a word this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out holds a valid bit
- ser_last  output  1  current beat is the final beat of the word
- ser_ready  input  1  downstream accepts the current beat
- busy  output  1  high while state is SHIFT

Behaviour:
- All state updates occur on the rising edge of clk. rst is sampled on that edge only.
- Reset values:
  - State = IDLE; shift register = 0; bit counter = 0; dir register = 0.
  - ser_valid = 0, ser_last = 0, ser_out = 0, busy = 0.
  - in_ready = 0 during any cycle in which rst = 1.
- State IDLE:
  - in_ready = 1 and ser_valid = 0.
  - in_valid = 1 → load in_data into the shift register, latch in_dir, clear the counter, go to SHIFT.
- State SHIFT:
  - ser_valid = 1 and busy = 1.
  - ser_out = shreg[0] when dir = 0; ser_out = shreg[WIDTH-1] when dir = 1. ser_out is driven from registers only.
  - ser_ready = 0 (stall): shift register, counter, ser_out and ser_last all hold.
  - ser_ready = 1: shift one position (right when dir = 0, left when dir = 1, zero-filled) and increment the counter.
- Last beat:
  - ser_last = 1 when counter = WIDTH-1.
  - Beat accepted (ser_ready = 1) with no new word → return to IDLE.
- in_ready = IDLE OR (SHIFT AND ser_last AND ser_ready). This is the only combinational path from ser_ready to in_ready.
- Back-to-back load: if in_valid = 1 on an accepted last beat, load the new word and stay in SHIFT. No bubble: ser_valid stays 1.
- Latency: word accepted at edge N → first bit valid in cycle N+1. Exactly WIDTH accepted beats per word.
- Upstream changes to in_data or in_dir while in SHIFT have no effect on the word in progress.
- Reset mid-word: the partial word is discarded. No further beats; outputs take reset values on the next edge.
- in_valid = 1 and rst = 1 in the same cycle: the word is not accepted. Upstream must hold it.

Optional Feature:
- Macro: SHIFT_SER_PARITY_EN.
- Defined:
  - One extra beat follows the data bits; the word is WIDTH+1 beats.
  - The extra bit is the XOR of the captured word (even parity).
  - ser_last asserts on the parity beat only. Counter terminal value is WIDTH.
  - Back-to-back loading applies on the parity beat.
- Undefined: WIDTH beats; no parity logic is synthesized.

Test Plan:
- Reset: rst = 1 for 2 cycles with in_valid = 1, in_data = 0xFF → in_ready = 0, ser_valid = 0, no load. After release, in_ready = 1 and busy = 0.
- LSB-first, no stall: in_data = 0xA5, in_dir = 0, ser_ready = 1 → ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept. ser_last only on the 8th beat. in_ready returns to 1.
- MSB-first with stalls: in_data = 0x81, in_dir = 1; ser_ready low on beats 2 and 5 for 3 cycles each → ser_out sequence is 1,0,0,0,0,0,0,1, each bit held during stalls. Total 14 valid cycles.
- Back-to-back: 0x0F (LSB-first), then 0xF0 presented before the last beat → 16 continuous ser_valid cycles with ser_out = 1111 0000 0000 1111. ser_last on beats 8 and 16.
- Reset mid-word: load 0xC3, accept 3 beats, assert rst for 1 cycle → ser_valid = 0 next cycle. A subsequent 0x01 word serializes cleanly with no leftover bits.
- SHIFT_SER_PARITY_EN defined, 0x07 LSB-first → 9 beats: 1,1,1,0,0,0,0,0,1. ser_last on beat 9 only.
